// File: rtl/ddr_bw_sched.sv
// ddr_bw_sched: per-app signed token buckets gating AR/AW issue,
// configured and read back over the softreg bus.
module ddr_bw_sched #(
  parameter int          NAPPS   = 4,
  parameter logic [31:0] SR_ADDR = 32'h20,
  parameter int          TOK_W   = 16
) (
  input  logic               aclk,
  input  logic               rst_n,
  input  logic               sr_valid,
  input  logic               sr_isWrite,
  input  logic [31:0]        sr_addr,
  input  logic [63:0]        sr_data,
  output logic               sr_resp_valid,
  output logic [63:0]        sr_resp_data,
  input  logic [NAPPS-1:0]   ar_fire,
  input  logic [NAPPS*8-1:0] ar_len,
  input  logic [NAPPS-1:0]   aw_fire,
  input  logic [NAPPS*8-1:0] aw_len,
  output logic [NAPPS-1:0]   ar_allow,
  output logic [NAPPS-1:0]   aw_allow
);
  localparam int NREG = 2 + 2 * NAPPS;
  localparam int XW   = TOK_W + 2;

  typedef logic signed [TOK_W-1:0] tok_t;
  typedef logic signed [XW-1:0]    ext_t;

  localparam ext_t T_MAX = {3'b000, {(TOK_W-1){1'b1}}};
  localparam ext_t T_MIN = {3'b111, {(TOK_W-1){1'b0}}};

  logic [NAPPS-1:0] en_mask;
  logic [15:0]      period;
  logic [15:0]      period_cnt;
  logic [15:0]      cnt_last;
  logic [15:0]      rate   [NAPPS];
  logic [15:0]      burst  [NAPPS];
  tok_t             tokens [NAPPS];
  tok_t             tok_nxt[NAPPS];
  logic             refill;
  logic [31:0]      off;
  logic             hit;
  logic             wr;
  logic             rd;
  logic [63:0]      rd_data;
  logic             unused;

  function automatic ext_t cap(input logic [15:0] b);
    ext_t be;
    be = signed'(XW'(b));
    return (be < T_MAX) ? be : T_MAX;
  endfunction

  function automatic tok_t ld(input logic [15:0] b);
    ext_t c;
    c = cap(b);
    return c[TOK_W-1:0];
  endfunction

  // all terms land together, then clip to [min, min(burst, max)]
  function automatic tok_t upd(
    input tok_t        tok,
    input logic [15:0] r,
    input logic [15:0] b,
    input logic        add,
    input logic        af,
    input logic [7:0]  al,
    input logic        wf,
    input logic [7:0]  wl
  );
    ext_t t;
    ext_t hi;
    t  = {{2{tok[TOK_W-1]}}, tok};
    hi = cap(b);
    if (add) t = t + signed'(XW'(r));
    if (af)  t = t - signed'(XW'(al)) - ext_t'(1);
    if (wf)  t = t - signed'(XW'(wl)) - ext_t'(1);
    if (t > hi)         t = hi;
    else if (t < T_MIN) t = T_MIN;
    return t[TOK_W-1:0];
  endfunction

  assign off = sr_addr - SR_ADDR;
  assign hit = off < 32'(NREG);
  assign wr  = sr_valid & sr_isWrite & hit;
  assign rd  = sr_valid & ~sr_isWrite & hit;

  assign cnt_last = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign refill   = period_cnt == cnt_last;

  assign unused = ^sr_data[63:32];

  always_comb begin
    for (int i = 0; i < NAPPS; i++) begin
      tok_nxt[i] = upd(tokens[i], rate[i], burst[i], refill,
                       ar_fire[i], ar_len[i*8 +: 8],
                       aw_fire[i], aw_len[i*8 +: 8]);
    end
  end

  always_comb begin
    for (int i = 0; i < NAPPS; i++) begin
      ar_allow[i] = ~en_mask[i] |
                    (~tokens[i][TOK_W-1] & (|tokens[i]));
    end
    aw_allow = ar_allow;
  end

  always_comb begin
    rd_data = '0;
    if (off == 32'd0) rd_data = 64'(en_mask);
    else if (off == 32'd1) rd_data = 64'(period);
    for (int i = 0; i < NAPPS; i++) begin
      if (off == 32'(2 + i))
        rd_data = {32'd0, burst[i], rate[i]};
      if (off == 32'(2 + NAPPS + i))
        rd_data = {{(64-TOK_W){tokens[i][TOK_W-1]}}, tokens[i]};
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      en_mask       <= '0;
      period        <= '0;
      period_cnt    <= '0;
      sr_resp_valid <= 1'b0;
      sr_resp_data  <= '0;
      for (int i = 0; i < NAPPS; i++) begin
        rate[i]   <= '0;
        burst[i]  <= '0;
        tokens[i] <= '0;
      end
    end else begin
      sr_resp_valid <= rd;
      sr_resp_data  <= rd ? rd_data : '0;
      if (wr && off == 32'd0) en_mask <= sr_data[NAPPS-1:0];
      if (wr && off == 32'd1) period <= sr_data[15:0];
      if ((wr && off == 32'd1) || refill) period_cnt <= '0;
      else period_cnt <= period_cnt + 16'd1;
      // a config load wins over same-cycle refill and charges
      for (int i = 0; i < NAPPS; i++) begin
        if (wr && off == 32'(2 + i)) begin
          rate[i]   <= sr_data[15:0];
          burst[i]  <= sr_data[31:16];
          tokens[i] <= ld(sr_data[31:16]);
        end else begin
          tokens[i] <= tok_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_bw_sched.sv
// tb_ddr_bw_sched: directed scenarios plus random traffic,
// checked every cycle against a token-bucket reference model.
module tb_ddr_bw_sched;
  localparam int          NA   = 4;
  localparam logic [31:0] BASE = 32'h20;
  localparam int          NREG = 2 + 2 * NA;

  logic        aclk = 1'b0;
  logic        rst_n;
  logic        sr_valid;
  logic        sr_isWrite;
  logic [31:0] sr_addr;
  logic [63:0] sr_data;
  logic        sr_resp_valid;
  logic [63:0] sr_resp_data;
  logic [3:0]  ar_fire;
  logic [31:0] ar_len;
  logic [3:0]  aw_fire;
  logic [31:0] aw_len;
  logic [3:0]  ar_allow;
  logic [3:0]  aw_allow;

  int tests = 0;
  int fails = 0;

  int          m_tok[NA];
  int          m_rate[NA];
  int          m_burst[NA];
  int          m_period;
  int          m_cnt;
  logic [3:0]  m_en;
  bit          m_rv;
  logic [63:0] m_rd;

  ddr_bw_sched #(.NAPPS(NA), .SR_ADDR(BASE), .TOK_W(16)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .sr_valid(sr_valid), .sr_isWrite(sr_isWrite),
    .sr_addr(sr_addr), .sr_data(sr_data),
    .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
    .ar_fire(ar_fire), .ar_len(ar_len),
    .aw_fire(aw_fire), .aw_len(aw_len),
    .ar_allow(ar_allow), .aw_allow(aw_allow)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_tok[i] = 0; m_rate[i] = 0; m_burst[i] = 0;
    end
    m_period = 0; m_cnt = 0; m_en = '0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [31:0] off;
    int pm, t, hi, k;
    bit refill;
    off = sr_addr - BASE;
    pm = (m_period == 0) ? 1 : m_period;
    refill = (m_cnt == pm - 1);
    m_rv = sr_valid && !sr_isWrite && (off < NREG);
    m_rd = '0;
    if (m_rv) begin
      k = int'(off);
      if (k == 0) m_rd = 64'(m_en);
      else if (k == 1) m_rd = 64'(m_period);
      else if (k < 2 + NA)
        m_rd = {32'd0, 16'(m_burst[k-2]), 16'(m_rate[k-2])};
      else m_rd = 64'(m_tok[k-2-NA]);
    end
    for (int i = 0; i < NA; i++) begin
      t = m_tok[i];
      if (refill) t += m_rate[i];
      if (ar_fire[i]) t -= int'(ar_len[i*8 +: 8]) + 1;
      if (aw_fire[i]) t -= int'(aw_len[i*8 +: 8]) + 1;
      hi = (m_burst[i] < 32767) ? m_burst[i] : 32767;
      if (t > hi) t = hi;
      if (t < -32768) t = -32768;
      m_tok[i] = t;
    end
    m_cnt = (m_cnt + 1) % pm;
    if (sr_valid && sr_isWrite && off < NREG) begin
      k = int'(off);
      if (k == 0) m_en = sr_data[3:0];
      else if (k == 1) begin
        m_period = int'(sr_data[15:0]);
        m_cnt = 0;
      end else if (k < 2 + NA) begin
        m_rate[k-2]  = int'(sr_data[15:0]);
        m_burst[k-2] = int'(sr_data[31:16]);
        m_tok[k-2]   = (m_burst[k-2] < 32767) ? m_burst[k-2] : 32767;
      end
    end
  endtask

  task automatic check_outs();
    logic [3:0] ea;
    for (int i = 0; i < NA; i++) ea[i] = !m_en[i] || (m_tok[i] > 0);
    chk("ar_allow", 64'(ar_allow), 64'(ea));
    chk("aw_allow", 64'(aw_allow), 64'(ea));
    chk("resp_valid", 64'(sr_resp_valid), 64'(m_rv));
    if (m_rv) chk("resp_data", sr_resp_data, m_rd);
  endtask

  task automatic cyc();
    @(posedge aclk);
    model_step();
    #1;
    check_outs();
    sr_valid = 0; sr_isWrite = 0;
    ar_fire = '0; aw_fire = '0; ar_len = '0; aw_len = '0;
  endtask

  task automatic wr(input int o, input logic [63:0] d);
    sr_valid = 1; sr_isWrite = 1;
    sr_addr = BASE + 32'(o); sr_data = d;
    cyc();
  endtask

  task automatic rda(input logic [31:0] a);
    sr_valid = 1; sr_isWrite = 0; sr_addr = a; sr_data = '0;
    cyc();
  endtask

  task automatic rd(input int o);
    rda(BASE + 32'(o));
  endtask

  initial begin
    rst_n = 0; sr_valid = 0; sr_isWrite = 0;
    sr_addr = '0; sr_data = '0;
    ar_fire = '0; aw_fire = '0; ar_len = '0; aw_len = '0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ar_allow", 64'(ar_allow), 64'hF);
    chk("rst_aw_allow", 64'(aw_allow), 64'hF);
    chk("rst_resp_valid", 64'(sr_resp_valid), 0);
    chk("rst_resp_data", sr_resp_data, 0);
    @(negedge aclk);
    rst_n = 1;

    rd(0);
    chk("t1_rd0_valid", 64'(sr_resp_valid), 1);
    chk("t1_rd0_data", sr_resp_data, 0);
    rda(BASE - 32'd1);
    chk("t1_unmapped", 64'(sr_resp_valid), 0);

    wr(0, 64'd1);
    wr(1, 64'd4);
    wr(2, {32'd0, 16'd16, 16'd8});
    ar_fire = 4'b0001; ar_len = 32'd15;
    cyc();
    chk("t2_block", 64'(ar_allow[0]), 0);
    rd(6);
    chk("t2_tok_zero", sr_resp_data, 0);
    cyc();
    rd(6);
    chk("t2_tok_refill", sr_resp_data, 8);
    chk("t2_allow_back", 64'(ar_allow[0]), 1);
    repeat (40) cyc();
    rd(6);
    chk("t2_tok_hold", sr_resp_data, 16);

    wr(1, 64'd4);
    ar_fire = 4'b0001; ar_len = 32'd11;
    cyc();
    cyc();
    cyc();
    ar_fire = 4'b0001; ar_len = 32'd3;
    aw_fire = 4'b0001; aw_len = 32'd7;
    cyc();
    chk("t3_ar_drop", 64'(ar_allow[0]), 0);
    chk("t3_aw_drop", 64'(aw_allow[0]), 0);
    rd(6);
    chk("t3_tok", sr_resp_data, 0);

    ar_fire = 4'b0001; ar_len = 32'd19;
    wr(0, 64'd0);
    chk("t4_dis_allow", 64'(ar_allow[0]), 1);
    wr(1, 64'd4);
    wr(0, 64'd1);
    chk("t4_en_block", 64'(aw_allow[0]), 0);
    repeat (10) cyc();
    chk("t4_still_block", 64'(ar_allow[0]), 0);
    repeat (2) cyc();
    chk("t4_reopen", 64'(ar_allow[0]), 1);
    rd(6);
    chk("t4_tok", sr_resp_data, 4);

    ar_fire = 4'b0010; ar_len = 32'd0;
    wr(3, {32'd0, 16'd32, 16'd4});
    rd(7);
    chk("t5_tok1", sr_resp_data, 32);

    wr(1, 64'd0);
    wr(2, {32'd0, 16'd16, 16'd1});
    for (int n = 0; n < 20; n++) begin
      ar_fire = 4'b0001; ar_len = 32'd0;
      cyc();
    end
    ar_fire = 4'b0001; ar_len = 32'd0;
    rd(6);
    chk("t6_tok_const", sr_resp_data, 16);
    chk("t6_allow", 64'(ar_allow[0]), 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sr_valid = 1;
        sr_isWrite = 1'($urandom_range(0, 1));
        sr_addr = BASE - 32'd1 + 32'($urandom_range(0, NREG + 1));
        if ($urandom_range(0, 7) == 0) sr_data = {$urandom, $urandom};
        else sr_data = {32'd0, 16'($urandom_range(0, 300)),
                        16'($urandom_range(0, 40))};
      end
      ar_fire = 4'($urandom);
      aw_fire = 4'($urandom);
      ar_len = ($urandom_range(0, 9) == 0) ? $urandom
                                           : ($urandom & 32'h0F0F0F0F);
      aw_len = $urandom & 32'h1F1F1F1F;
      cyc();
    end

    wr(0, 64'hF);
    ar_fire = 4'hF; ar_len = 32'hFFFFFFFF;
    aw_fire = 4'hF; aw_len = 32'hFFFFFFFF;
    cyc();
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("mid_rst_ar_allow", 64'(ar_allow), 64'hF);
    chk("mid_rst_aw_allow", 64'(aw_allow), 64'hF);
    chk("mid_rst_resp_valid", 64'(sr_resp_valid), 0);
    chk("mid_rst_resp_data", sr_resp_data, 0);
    #2 rst_n = 1;
    rd(0);
    chk("post_rst_en", sr_resp_data, 0);
    rd(1);
    chk("post_rst_period", sr_resp_data, 0);
    rd(2);
    chk("post_rst_cfg0", sr_resp_data, 0);
    rd(6);
    chk("post_rst_tok0", sr_resp_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
